// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped data cache controller.
// Provides the FSM state encoding, address-field width helpers derived
// from the LINES/WORDS geometry, and the byte-strobe merge helper.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Word-offset field width (selects a word inside a line).
  function automatic int off_bits(input int words);
    return $clog2(words);
  endfunction

  // Index field width (selects a line).
  function automatic int idx_bits(input int lines);
    return $clog2(lines);
  endfunction

  // Tag width: what is left of the 30-bit word address.
  function automatic int tag_bits(input int lines, input int words);
    return 30 - $clog2(words) - $clog2(lines);
  endfunction

  // Overlay the enabled bytes of new_w onto old_w.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage for the direct-mapped data cache.
// Ports:
//   clk, rst            clock, asynchronous active-low reset (clears valid bits)
//   rd_index/rd_offset  asynchronous read address
//   rd_valid/rd_tag/rd_data  read results for the addressed line/word
//   wr_en, wr_index, wr_offset, wr_data, wr_strb  byte-strobed word write
//   set_en, set_tag     mark line wr_index valid with tag set_tag
module dcache_array
  import cache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4,
  localparam int OFF_W = off_bits(WORDS),
  localparam int IDX_W = idx_bits(LINES),
  localparam int TAG_W = tag_bits(LINES, WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_index,
  input  logic [OFF_W-1:0] rd_offset,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [OFF_W-1:0] wr_offset,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_strb,
  input  logic             set_en,
  input  logic [TAG_W-1:0] set_tag
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [TAG_W-1:0] tag_d  [LINES];
  logic [31:0]      data_q [LINES][WORDS];
  logic [31:0]      data_d [LINES][WORDS];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index][rd_offset];

  // Next-state of the storage: one strobed word write and/or one line-valid set.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) begin
      data_d[wr_index][wr_offset] =
        merge_bytes(data_q[wr_index][wr_offset], wr_data, wr_strb);
    end else begin
      data_d[wr_index][wr_offset] = data_q[wr_index][wr_offset];
    end
    if (set_en) begin
      valid_d[wr_index] = 1'b1;
      tag_d[wr_index]   = set_tag;
    end else begin
      valid_d[wr_index] = valid_q[wr_index];
    end
  end

  // Valid bits: cleared by reset so no stale or half-filled line survives it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= {LINES{1'b0}};
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data storage carry no reset; they are qualified by the valid bits.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller
// sitting between the MEM stage and external memory.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   core_req/core_we/core_addr/core_wdata/core_wstrb  MEM-stage access
//   core_rdata                 load data, valid with PReady on a load
//   stop                       freeze the pipeline
//   PReady                     access completes this cycle
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb  memory request
//   mem_rdata/mem_ready        memory response, one ack per word
module dcache_ctrl
  import cache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [3:0]  core_wstrb,
  output logic [31:0] core_rdata,
  output logic        stop,
  output logic        PReady,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int OFF_W = off_bits(WORDS);
  localparam int IDX_W = idx_bits(LINES);
  localparam int TAG_W = tag_bits(LINES, WORDS);

  state_e           state_q, state_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic [29:0]      waddr_q, waddr_d;   // latched word address
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;

  logic [29:0]      lk_waddr_s;
  logic             hit_s;
  logic             arr_valid_s;
  logic [TAG_W-1:0] arr_tag_s;
  logic [31:0]      arr_data_s;
  logic             wr_en_s;
  logic [OFF_W-1:0] wr_offset_s;
  logic [31:0]      wr_data_s;
  logic [3:0]       wr_strb_s;
  logic             set_en_s;

  logic             stop_s, pready_s, mem_req_s, mem_we_s;
  logic [31:0]      mem_addr_s, mem_wdata_s, rdata_s;
  logic [3:0]       mem_wstrb_s;
  logic             unused_addr_s;

  assign unused_addr_s = ^core_addr[1:0];

  // In IDLE the live request is looked up; afterwards only the latched one matters.
  assign lk_waddr_s = (state_q == IDLE) ? core_addr[31:2] : waddr_q;
  assign hit_s      = arr_valid_s && (arr_tag_s == lk_waddr_s[29:OFF_W+IDX_W]);

  dcache_array #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_index  (lk_waddr_s[OFF_W+IDX_W-1:OFF_W]),
    .rd_offset (lk_waddr_s[OFF_W-1:0]),
    .rd_valid  (arr_valid_s),
    .rd_tag    (arr_tag_s),
    .rd_data   (arr_data_s),
    .wr_en     (wr_en_s),
    .wr_index  (waddr_q[OFF_W+IDX_W-1:OFF_W]),
    .wr_offset (wr_offset_s),
    .wr_data   (wr_data_s),
    .wr_strb   (wr_strb_s),
    .set_en    (set_en_s),
    .set_tag   (waddr_q[29:OFF_W+IDX_W])
  );

  // Next-state, request latch and combinational outputs of the controller FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    stop_s      = 1'b0;
    pready_s    = 1'b0;
    mem_req_s   = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = 32'd0;
    mem_wdata_s = 32'd0;
    mem_wstrb_s = 4'd0;
    rdata_s     = arr_data_s;
    wr_en_s     = 1'b0;
    wr_offset_s = waddr_q[OFF_W-1:0];
    wr_data_s   = mem_rdata;
    wr_strb_s   = 4'hF;
    set_en_s    = 1'b0;

    case (state_q)
      IDLE: begin
        if (core_req) begin
          if (!core_we && hit_s) begin
            pready_s = 1'b1;
          end else begin
            stop_s  = 1'b1;
            waddr_d = core_addr[31:2];
            wdata_d = core_wdata;
            wstrb_d = core_wstrb;
            cnt_d   = {OFF_W{1'b0}};
            state_d = core_we ? WRITE : REFILL;
          end
        end else begin
          stop_s = 1'b0;
        end
      end

      REFILL: begin
        stop_s      = 1'b1;
        mem_req_s   = 1'b1;
        mem_addr_s  = {waddr_q[29:OFF_W], cnt_q, 2'b00};
        wr_offset_s = cnt_q;
        if (mem_ready) begin
          wr_en_s = 1'b1;
          cnt_d   = cnt_q + OFF_W'(1);
          if (cnt_q == OFF_W'(WORDS - 1)) begin
            set_en_s = 1'b1;
            state_d  = DONE;
          end else begin
            state_d = REFILL;
          end
        end else begin
          state_d = REFILL;
        end
      end

      WRITE: begin
        stop_s      = 1'b1;
        mem_req_s   = 1'b1;
        mem_we_s    = 1'b1;
        mem_addr_s  = {waddr_q, 2'b00};
        mem_wdata_s = wdata_q;
        mem_wstrb_s = wstrb_q;
        wr_data_s   = wdata_q;
        wr_strb_s   = wstrb_q;
        if (mem_ready) begin
          // Write-through: the cached copy is touched only when the line is present.
          wr_en_s = hit_s;
          state_d = DONE;
        end else begin
          state_d = WRITE;
        end
      end

      DONE: begin
        pready_s = 1'b1;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state, refill counter and latched request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= {OFF_W{1'b0}};
      waddr_q <= 30'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  // Outputs are forced quiet while reset is asserted, even with a request pending.
  assign stop       = rst & stop_s;
  assign PReady     = rst & pready_s;
  assign mem_req    = rst & mem_req_s;
  assign mem_we     = rst & mem_we_s;
  assign mem_addr   = rst ? mem_addr_s  : 32'd0;
  assign mem_wdata  = rst ? mem_wdata_s : 32'd0;
  assign mem_wstrb  = rst ? mem_wstrb_s : 4'd0;
  assign core_rdata = rst ? rdata_s     : 32'd0;

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

  localparam int LINES = 16;
  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        core_req = 1'b0;
  logic        core_we = 1'b0;
  logic [31:0] core_addr = 32'd0;
  logic [31:0] core_wdata = 32'd0;
  logic [3:0]  core_wstrb = 4'd0;
  logic [31:0] core_rdata;
  logic        stop;
  logic        PReady;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  dcache_ctrl #(.LINES(LINES), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_wstrb(core_wstrb), .core_rdata(core_rdata),
    .stop(stop), .PReady(PReady),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: cache contents and backing memory, kept as plain arrays.
  bit          m_valid [LINES];
  int unsigned m_tag   [LINES];
  bit [31:0]   m_data  [LINES][WORDS];
  bit [31:0]   mem_store [bit [31:0]];

  function automatic bit [31:0] mem_rd(input bit [31:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic int unsigned f_off(input bit [31:0] a);
    return (a / 4) % WORDS;
  endfunction

  function automatic int unsigned f_idx(input bit [31:0] a);
    return (a / (4 * WORDS)) % LINES;
  endfunction

  function automatic int unsigned f_tag(input bit [31:0] a);
    return a / (4 * WORDS * LINES);
  endfunction

  function automatic bit [31:0] merge(input bit [31:0] o, input bit [31:0] n, input bit [3:0] s);
    bit [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  // One complete core access, acting as the memory too; returns with the
  // request still up when b2b is set so the next access follows DONE directly.
  task automatic do_access(input bit we, input bit [31:0] addr, input bit [31:0] wdata,
                           input bit [3:0] wstrb, input int lat, input bit perturb,
                           input bit b2b);
    bit [31:0]   wa, base, baddr;
    int unsigned idx, off;
    bit          hit;
    int          nbeats;
    bit [31:0]   line [WORDS];
    wa   = addr & 32'hFFFF_FFFC;
    base = addr & ~(32'(4 * WORDS) - 32'd1);
    idx  = f_idx(addr);
    off  = f_off(addr);
    hit  = m_valid[idx] && (m_tag[idx] == f_tag(addr));

    @(negedge clk);
    core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata; core_wstrb = wstrb;
    mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    #1;
    if (!we && hit) begin
      check_eq("hit_stop", 32'(stop), 32'd0);
      check_eq("hit_pready", 32'(PReady), 32'd1);
      check_eq("hit_rdata", core_rdata, m_data[idx][off]);
      check_eq("hit_memreq", 32'(mem_req), 32'd0);
    end else begin
      check_eq("req_stop", 32'(stop), 32'd1);
      check_eq("req_pready", 32'(PReady), 32'd0);
      nbeats = we ? 1 : WORDS;
      for (int b = 0; b < nbeats; b++) begin
        baddr = we ? wa : base + 32'(4 * b);
        for (int c = 1; c <= lat; c++) begin
          @(negedge clk);
          if (perturb) begin
            core_addr = $urandom; core_we = 1'($urandom_range(0, 1));
            core_wdata = $urandom; core_wstrb = 4'($urandom);
          end
          mem_ready = (c == lat);
          mem_rdata = (we || c != lat) ? $urandom : mem_rd(baddr);
          if (!we && c == lat) line[b] = mem_rdata;
          #1;
          check_eq("beat_memreq", 32'(mem_req), 32'd1);
          check_eq("beat_addr", mem_addr, baddr);
          check_eq("beat_we", 32'(mem_we), 32'(we));
          check_eq("beat_stop", 32'(stop), 32'd1);
          check_eq("beat_pready", 32'(PReady), 32'd0);
          if (we) begin
            check_eq("beat_wdata", mem_wdata, wdata);
            check_eq("beat_wstrb", 32'(mem_wstrb), 32'(wstrb));
          end
        end
      end
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      #1;
      check_eq("done_pready", 32'(PReady), 32'd1);
      check_eq("done_stop", 32'(stop), 32'd0);
      check_eq("done_memreq", 32'(mem_req), 32'd0);
      if (we) begin
        mem_store[wa] = merge(mem_rd(wa), wdata, wstrb);
        if (hit) m_data[idx][off] = merge(m_data[idx][off], wdata, wstrb);
      end else begin
        for (int w = 0; w < WORDS; w++) m_data[idx][w] = line[w];
        m_valid[idx] = 1'b1;
        m_tag[idx] = f_tag(addr);
        check_eq("done_rdata", core_rdata, m_data[idx][off]);
      end
    end
    if (!b2b) begin
      @(negedge clk);
      core_req = 1'b0;
      mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      #1;
      check_eq("idle_stop", 32'(stop), 32'd0);
      check_eq("idle_pready", 32'(PReady), 32'd0);
      check_eq("idle_memreq", 32'(mem_req), 32'd0);
    end
  endtask

  initial begin
    bit [31:0] ra;
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    for (int i = 0; i < WORDS; i++) mem_store[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);

    // Reset state, with a request pending to show the outputs stay quiet.
    core_req = 1'b1; core_addr = 32'h104;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_stop", 32'(stop), 32'd0);
    check_eq("rst_pready", 32'(PReady), 32'd0);
    check_eq("rst_memreq", 32'(mem_req), 32'd0);
    check_eq("rst_memwe", 32'(mem_we), 32'd0);
    check_eq("rst_memaddr", mem_addr, 32'd0);
    check_eq("rst_memwdata", mem_wdata, 32'd0);
    check_eq("rst_memwstrb", 32'(mem_wstrb), 32'd0);
    check_eq("rst_rdata", core_rdata, 32'd0);
    @(negedge clk);
    core_req = 1'b0; rst = 1'b1;

    // Cold miss, hit, write hit and read-back.
    do_access(1'b0, 32'h104, 32'd0, 4'd0, 2, 1'b0, 1'b0);
    do_access(1'b0, 32'h10C, 32'd0, 4'd0, 1, 1'b0, 1'b0);
    do_access(1'b1, 32'h108, 32'hDEADBEEF, 4'b0011, 2, 1'b0, 1'b0);
    do_access(1'b0, 32'h108, 32'd0, 4'd0, 1, 1'b0, 1'b0);
    check_eq("wr_merge", core_rdata, 32'h0000BEEF);

    // Write miss does not allocate.
    do_access(1'b1, 32'h2000, 32'h12345678, 4'b1111, 1, 1'b0, 1'b0);
    do_access(1'b0, 32'h2000, 32'd0, 4'd0, 1, 1'b0, 1'b0);

    // Conflict on index 0.
    do_access(1'b0, 32'h104, 32'd0, 4'd0, 1, 1'b0, 1'b0);
    do_access(1'b0, 32'h504, 32'd0, 4'd0, 1, 1'b0, 1'b0);
    do_access(1'b0, 32'h104, 32'd0, 4'd0, 1, 1'b0, 1'b0);

    // Reset in the middle of a refill of 0x504.
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h504; mem_ready = 1'b0;
    #1;
    check_eq("mr_stop", 32'(stop), 32'd1);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      mem_ready = 1'b1; mem_rdata = mem_rd(32'h500 + 32'(4 * b));
      #1;
      check_eq("mr_addr", mem_addr, 32'h500 + 32'(4 * b));
    end
    @(negedge clk);
    mem_ready = 1'b0; rst = 1'b0;
    #1;
    check_eq("mr_rst_memreq", 32'(mem_req), 32'd0);
    check_eq("mr_rst_stop", 32'(stop), 32'd0);
    check_eq("mr_rst_pready", 32'(PReady), 32'd0);
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    @(negedge clk);
    core_req = 1'b0; rst = 1'b1;
    do_access(1'b0, 32'h104, 32'd0, 4'd0, 1, 1'b0, 1'b0);
    do_access(1'b0, 32'h504, 32'd0, 4'd0, 1, 1'b0, 1'b0);

    // Randomized mix over a few tags so hits, misses and conflicts all occur.
    for (int n = 0; n < 400; n++) begin
      ra = 32'($urandom_range(0, 255)) * 32'd4;
      if ($urandom_range(0, 9) < 3)
        do_access(1'b1, ra, $urandom, 4'($urandom), int'($urandom_range(1, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        do_access(1'b0, ra, 32'd0, 4'd0, int'($urandom_range(1, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    core_req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
